// File: rtl/mc_pkg.sv
// Shared MC-stage definitions: scan sequencer state encoding and default
// coordinate/counter widths used by MC top, the scan sequencer and the filter datapath.
package mc_pkg;

  localparam int MC_COORD_W = 8;
  localparam int MC_CNT_W   = 16;

  typedef enum logic [1:0] {
    LFS_IDLE,
    LFS_LOAD,
    LFS_REQ,
    LFS_DONE
  } lfs_state_t;

endpackage

// File: rtl/mb_raster_cnt.sv
// Raster-order macroblock coordinate counter: clears to (0,0), advances x then
// wraps into the next row, and flags the bottom-right macroblock of the frame.
module mb_raster_cnt
  import mc_pkg::*;
#(
  parameter int COORD_W = MC_COORD_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               adv,
  input  logic [COORD_W-1:0] w,
  input  logic [COORD_W-1:0] h,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               last
);

  localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic               x_end;

  // w/h are only non-zero while a frame is scanning, so w-1/h-1 never matter when zero
  assign x_end = (x_q == w - ONE);
  assign last  = x_end && (y_q == h - ONE);

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr) begin
      x_d = '0;
      y_d = '0;
    end else if (adv) begin
      if (x_end) begin
        x_d = '0;
        y_d = y_q + ONE;
      end else begin
        x_d = x_q + ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x = x_q;
  assign y = y_q;

endmodule

// File: rtl/lf_conceal_scan.sv
// Loop-filter/concealment scan sequencer: on a rising LF_conceal it walks the
// macroblock grid in raster order, one req/ack request per macroblock, then pulses frame_done.
module lf_conceal_scan
  import mc_pkg::*;
#(
  parameter int COORD_W = MC_COORD_W,
  parameter int CNT_W   = MC_CNT_W
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic [COORD_W-1:0] height,
  input  logic [COORD_W-1:0] width,
  input  logic               LF_conceal,
  output logic               mb_req,
  input  logic               mb_ack,
  output logic [COORD_W-1:0] mb_x,
  output logic [COORD_W-1:0] mb_y,
  output logic               left_avail,
  output logic               top_avail,
  output logic               busy,
  output logic               frame_done,
  output logic [CNT_W-1:0]   mb_count
);

  lfs_state_t         state_q;
  logic               lf_q;
  logic               req_q;
  logic               busy_q;
  logic               done_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [COORD_W-1:0] w_q;
  logic [COORD_W-1:0] h_q;

  logic               start;
  logic               xfer;
  logic               last;
  logic               rc_clr;
  logic               rc_adv;

  assign start  = LF_conceal & ~lf_q;
  assign xfer   = req_q & mb_ack;
  assign rc_clr = (state_q == LFS_LOAD);
  // the final transfer leaves the coordinates parked on the last macroblock
  assign rc_adv = xfer & ~last;

  mb_raster_cnt #(
    .COORD_W (COORD_W)
  ) u_raster (
    .clk  (CLK),
    .rst  (reset),
    .clr  (rc_clr),
    .adv  (rc_adv),
    .w    (w_q),
    .h    (h_q),
    .x    (mb_x),
    .y    (mb_y),
    .last (last)
  );

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= LFS_IDLE;
      lf_q    <= 1'b0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      w_q     <= '0;
      h_q     <= '0;
    end else begin
      lf_q   <= LF_conceal;
      done_q <= 1'b0;
      case (state_q)
        LFS_IDLE: begin
          if (start) begin
            state_q <= LFS_LOAD;
            busy_q  <= 1'b1;
          end
        end
        LFS_LOAD: begin
          w_q   <= width;
          h_q   <= height;
          cnt_q <= '0;
          if ((width == '0) || (height == '0)) begin
            state_q <= LFS_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= LFS_REQ;
            req_q   <= 1'b1;
          end
        end
        LFS_REQ: begin
          if (xfer) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (last) begin
              state_q <= LFS_DONE;
              req_q   <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        LFS_DONE: begin
          state_q <= LFS_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= LFS_IDLE;
          req_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mb_req     = req_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign mb_count   = cnt_q;
  assign left_avail = (mb_x != '0);
  assign top_avail  = (mb_y != '0);

endmodule

// File: tb/tb_lf_conceal_scan.sv
// Self-checking bench for lf_conceal_scan: vector table, directed corner sequences,
// and randomized frames checked against a transaction-level raster model.
module tb_lf_conceal_scan;

  logic        CLK;
  logic        reset;
  logic [7:0]  height;
  logic [7:0]  width;
  logic        LF_conceal;
  logic        mb_req;
  logic        mb_ack;
  logic [7:0]  mb_x;
  logic [7:0]  mb_y;
  logic        left_avail;
  logic        top_avail;
  logic        busy;
  logic        frame_done;
  logic [15:0] mb_count;

  lf_conceal_scan #(
    .COORD_W (8),
    .CNT_W   (16)
  ) dut (
    .CLK        (CLK),
    .reset      (reset),
    .height     (height),
    .width      (width),
    .LF_conceal (LF_conceal),
    .mb_req     (mb_req),
    .mb_ack     (mb_ack),
    .mb_x       (mb_x),
    .mb_y       (mb_y),
    .left_avail (left_avail),
    .top_avail  (top_avail),
    .busy       (busy),
    .frame_done (frame_done),
    .mb_count   (mb_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       lf;
    logic       ack;
    logic [7:0] w;
    logic [7:0] h;
    logic       req;
    logic [7:0] x;
    logic [7:0] y;
    logic       lft;
    logic       top;
    logic       bsy;
    logic       dn;
    logic       cnt_chk;
    logic [15:0] cnt;
  } vec_t;

  function automatic vec_t mk(logic lf, logic ack, logic [7:0] w, logic [7:0] h,
                              logic req, logic [7:0] x, logic [7:0] y, logic lft, logic top,
                              logic bsy, logic dn, logic cnt_chk, logic [15:0] cnt);
    vec_t v;
    v.lf = lf; v.ack = ack; v.w = w; v.h = h; v.req = req; v.x = x; v.y = y;
    v.lft = lft; v.top = top; v.bsy = bsy; v.dn = dn; v.cnt_chk = cnt_chk; v.cnt = cnt;
    return v;
  endfunction

  // ---------------- random-phase monitor and model ----------------
  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
  } xy_t;

  xy_t        exp_q[$];
  int         exp_n     = 0;
  int         trig_cyc  = 0;
  logic       mon_en    = 1'b0;
  int         req_cycles = 0;
  int         done_cnt  = 0;
  logic       prev_req  = 1'b0;
  logic       prev_ack  = 1'b0;
  logic [7:0] prev_x    = '0;
  logic [7:0] prev_y    = '0;

  always @(negedge CLK) begin
    if (mon_en) begin
      if (mb_req) begin
        chk("rnd_left_avail", left_avail, (mb_x != 0));
        chk("rnd_top_avail", top_avail, (mb_y != 0));
        if (prev_req && !prev_ack) begin
          chk("rnd_hold_x", mb_x, prev_x);
          chk("rnd_hold_y", mb_y, prev_y);
        end
        if (mb_ack) begin
          if (exp_q.size() == 0) begin
            chk("rnd_extra_xfer", 1, 0);
          end else begin
            xy_t e;
            e = exp_q.pop_front();
            chk("rnd_xfer_x", mb_x, e.x);
            chk("rnd_xfer_y", mb_y, e.y);
          end
        end
      end
      if (frame_done) begin
        chk("rnd_missing_xfers", exp_q.size(), 0);
        chk("rnd_mb_count", mb_count, exp_n);
        chk("rnd_done_cycle", cyc, trig_cyc + 2 + req_cycles + (mb_req ? 1 : 0));
        done_cnt   <= done_cnt + 1;
        req_cycles <= 0;
      end else if (mb_req) begin
        req_cycles <= req_cycles + 1;
      end
      prev_req <= mb_req;
      prev_ack <= mb_ack;
      prev_x   <= mb_x;
      prev_y   <= mb_y;
    end else begin
      prev_req <= 1'b0;
      prev_ack <= 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit expected test end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[$];
    int   xfers;
    int   dones;
    int   d0;
    logic got;
    int   W;
    int   H;

    reset = 1'b1; LF_conceal = 1'b0; mb_ack = 1'b0; width = 8'd0; height = 8'd0;
    step(); step(); step();
    chk("rst_req", mb_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_x", mb_x, 0);
    chk("rst_y", mb_y, 0);
    chk("rst_left", left_avail, 0);
    chk("rst_top", top_avail, 0);
    chk("rst_cnt", mb_count, 0);
    reset = 1'b0;
    step(); step();
    chk("idle_busy", busy, 0);

    // 2x2 frame with ack tied high, then a zero-width frame
    vecs.push_back(mk(1, 1, 2, 2, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 2, 2, 1, 0, 0, 0, 0, 1, 0, 1, 0));
    vecs.push_back(mk(1, 1, 2, 2, 1, 1, 0, 1, 0, 1, 0, 1, 1));
    vecs.push_back(mk(0, 1, 2, 2, 1, 0, 1, 0, 1, 1, 0, 1, 2));
    vecs.push_back(mk(0, 1, 2, 2, 1, 1, 1, 1, 1, 1, 0, 1, 3));
    vecs.push_back(mk(0, 1, 2, 2, 0, 0, 0, 0, 0, 1, 1, 1, 4));
    vecs.push_back(mk(0, 1, 2, 2, 0, 0, 0, 0, 0, 0, 0, 1, 4));
    vecs.push_back(mk(0, 1, 0, 4, 0, 0, 0, 0, 0, 0, 0, 1, 4));
    vecs.push_back(mk(1, 1, 0, 4, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 4, 0, 0, 0, 0, 0, 1, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 4, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    for (int i = 0; i < vecs.size(); i++) begin
      LF_conceal = vecs[i].lf; mb_ack = vecs[i].ack;
      width = vecs[i].w; height = vecs[i].h;
      step();
      chk($sformatf("vec%0d_req", i), mb_req, vecs[i].req);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].bsy);
      chk($sformatf("vec%0d_done", i), frame_done, vecs[i].dn);
      if (vecs[i].cnt_chk) chk($sformatf("vec%0d_cnt", i), mb_count, vecs[i].cnt);
      if (vecs[i].req) begin
        chk($sformatf("vec%0d_x", i), mb_x, vecs[i].x);
        chk($sformatf("vec%0d_y", i), mb_y, vecs[i].y);
        chk($sformatf("vec%0d_left", i), left_avail, vecs[i].lft);
        chk($sformatf("vec%0d_top", i), top_avail, vecs[i].top);
      end
    end

    // backpressure: 3x1 frame, ack low for two cycles per macroblock
    width = 8'd3; height = 8'd1; mb_ack = 1'b0; LF_conceal = 1'b1;
    step(); step();
    for (int mb = 0; mb < 3; mb++) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("bp_req_%0d_%0d", mb, k), mb_req, 1);
        chk($sformatf("bp_x_%0d_%0d", mb, k), mb_x, mb);
        chk($sformatf("bp_y_%0d_%0d", mb, k), mb_y, 0);
        mb_ack = (k == 2);
        step();
      end
    end
    chk("bp_done", frame_done, 1);
    chk("bp_cnt", mb_count, 3);
    chk("bp_req_off", mb_req, 0);
    mb_ack = 1'b0; LF_conceal = 1'b0;
    step();
    chk("bp_done_once", frame_done, 0);
    chk("bp_busy_off", busy, 0);

    // retrigger and width change during a 4x4 frame
    width = 8'd4; height = 8'd4; mb_ack = 1'b1; LF_conceal = 1'b1;
    xfers = 0; dones = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (mb_req && mb_ack) xfers++;
      if (frame_done) dones++;
      if (k == 3) begin LF_conceal = 1'b0; width = 8'd1; end
      if (k == 6) LF_conceal = 1'b1;
      if (k == 20) LF_conceal = 1'b0;
    end
    chk("rt_xfers", xfers, 16);
    chk("rt_dones", dones, 1);
    chk("rt_cnt", mb_count, 16);
    chk("rt_busy", busy, 0);

    // LF_conceal held high through reset
    reset = 1'b1; LF_conceal = 1'b1; width = 8'd1; height = 8'd1; mb_ack = 1'b1;
    step(); step(); step();
    chk("hold_rst_busy", busy, 0);
    chk("hold_rst_cnt", mb_count, 0);
    reset = 1'b0;
    step();
    chk("hold_load_busy", busy, 1);
    chk("hold_load_req", mb_req, 0);
    step();
    chk("hold_req", mb_req, 1);
    chk("hold_x", mb_x, 0);
    step();
    chk("hold_done", frame_done, 1);
    chk("hold_cnt", mb_count, 1);
    LF_conceal = 1'b0;
    step();
    chk("hold_idle", busy, 0);

    // reset in the middle of an 8x8 frame
    width = 8'd8; height = 8'd8; mb_ack = 1'b1; LF_conceal = 1'b1;
    step(); step();
    for (int k = 0; k < 5; k++) step();
    chk("mid_cnt5", mb_count, 5);
    chk("mid_x5", mb_x, 5);
    reset = 1'b1; LF_conceal = 1'b0;
    step();
    chk("mid_rst_req", mb_req, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", frame_done, 0);
    chk("mid_rst_x", mb_x, 0);
    chk("mid_rst_y", mb_y, 0);
    chk("mid_rst_cnt", mb_count, 0);
    reset = 1'b0;
    step();
    chk("mid_idle_req", mb_req, 0);
    chk("mid_idle_busy", busy, 0);
    LF_conceal = 1'b1;
    step();
    chk("mid_load_busy", busy, 1);
    step();
    chk("mid_re_req", mb_req, 1);
    chk("mid_re_x", mb_x, 0);
    chk("mid_re_y", mb_y, 0);
    chk("mid_re_cnt", mb_count, 0);
    step();
    chk("mid_re_x1", mb_x, 1);
    chk("mid_re_cnt1", mb_count, 1);
    reset = 1'b1; LF_conceal = 1'b0;
    step();
    reset = 1'b0;
    step();

    // randomized frames against the raster model
    mon_en = 1'b1;
    for (int f = 0; f < 24; f++) begin
      W = $urandom_range(0, 5);
      H = $urandom_range(0, 5);
      width = 8'(W); height = 8'(H); LF_conceal = 1'b0;
      mb_ack = 1'($urandom_range(0, 1));
      step();
      for (int yi = 0; yi < H; yi++)
        for (int xi = 0; xi < W; xi++)
          exp_q.push_back('{x: 8'(xi), y: 8'(yi)});
      exp_n = W * H;
      d0 = done_cnt;
      LF_conceal = 1'b1;
      trig_cyc = cyc;
      got = 1'b0;
      for (int k = 0; k < 400; k++) begin
        step();
        if (done_cnt != d0) begin
          got = 1'b1;
          break;
        end
        mb_ack = ($urandom_range(0, 2) != 0);
        if ($urandom_range(0, 3) == 0) LF_conceal = ~LF_conceal;
        if (k >= 1) begin
          width  = 8'($urandom_range(0, 6));
          height = 8'($urandom_range(0, 6));
        end
      end
      chk($sformatf("rnd%0d_done_seen", f), got, 1);
      LF_conceal = 1'b0;
      step(); step();
      chk($sformatf("rnd%0d_single_done", f), done_cnt, d0 + 1);
      chk($sformatf("rnd%0d_busy_off", f), busy, 0);
      exp_q.delete();
    end
    mon_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
